// File: rtl/seq_mul_add_pkg.sv
// seq_mul_add_pkg
//   Shared definitions for the sequential multiply-add unit:
//   the controller state encoding and the default datapath width.
package seq_mul_add_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_mul_add_if.sv
// seq_mul_add_if
//   Request/result bundle of the sequential multiply-add unit.
//   master : drives start and the three operands, observes busy/done/result
//   slave  : the unit itself
//   Signals:
//     start              request, accepted only while the unit is idle
//     op_a, op_b, op_c   multiplicand, multiplier, addend (WIDTH bits)
//     busy               unit is running or signalling completion
//     done               one-cycle completion pulse
//     result             last completed (op_a * op_b + op_c) mod 2^WIDTH
interface seq_mul_add_if
    import seq_mul_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] op_c;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, op_a, op_b, op_c,
        input  busy, done, result
    );

    modport slave (
        input  start, op_a, op_b, op_c,
        output busy, done, result
    );

endinterface

// File: rtl/seq_mul_add_ctrl.sv
// seq_mul_add_ctrl
//   Sequencer of the shift-add multiply-add unit: IDLE -> RUN -> DONE -> IDLE,
//   plus the iteration counter that bounds RUN to WIDTH cycles.
//   Ports:
//     clk, reset   clock and synchronous active-high reset
//     start        request, only honoured in IDLE
//     skip         datapath reports there is nothing left to add; ends RUN now
//                  (tied low when early exit is not built in)
//     busy, done   registered status outputs (busy in RUN and DONE, done in DONE)
//     load         accept strobe: datapath captures the operands on this edge
//     step         datapath performs one shift-add iteration on this edge
//     finish       last RUN edge: datapath loads result on this edge
module seq_mul_add_ctrl
    import seq_mul_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic skip,
    output logic busy,
    output logic done,
    output logic load,
    output logic step,
    output logic finish
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             last_iter;

    // The edge seen with cnt == WIDTH-1 carries the final iteration.
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    // Strobes are decoded from registered state so the datapath acts on the
    // same edge the FSM transitions on.
    assign load   = (state == S_IDLE) && start;
    assign step   = (state == S_RUN) && !skip;
    assign finish = (state == S_RUN) && (skip || last_iter);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_RUN;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (finish) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    // start is deliberately not sampled here; requests are not queued.
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/seq_mul_add.sv
// seq_mul_add
//   Multi-cycle radix-2 shift-add unit: result = (op_a * op_b + op_c) mod 2^WIDTH,
//   one adder, one multiplier bit per clock.
//   Ports:
//     clk     single clock, all state on the rising edge
//     reset   synchronous, active-high; abandons any operation and clears result
//     bus     seq_mul_add_if.slave (start, op_a/op_b/op_c in; busy, done, result out)
//   Build option:
//     SEQ_MUL_ADD_EARLY_EXIT_EN  when defined, RUN ends as soon as the remaining
//                                multiplier bits are all zero. Results are identical,
//                                only latency changes.
module seq_mul_add
    import seq_mul_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    seq_mul_add_if.slave  bus
);

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] result_r;
    logic [WIDTH-1:0] next_acc;

    logic busy;
    logic done;
    logic load;
    logic step;
    logic finish;
    logic skip;

`ifdef SEQ_MUL_ADD_EARLY_EXIT_EN
    assign skip = (b_r == '0);
`else
    assign skip = 1'b0;
`endif

    // Single adder; the carry out of the top bit is dropped so everything wraps mod 2^WIDTH.
    assign next_acc = b_r[0] ? (acc + a_r) : acc;

    seq_mul_add_ctrl #(
        .WIDTH (WIDTH)
    ) u_ctrl (
        .clk    (clk),
        .reset  (reset),
        .start  (bus.start),
        .skip   (skip),
        .busy   (busy),
        .done   (done),
        .load   (load),
        .step   (step),
        .finish (finish)
    );

    // On a skipped edge b_r is zero, so next_acc equals acc and the same
    // expression serves both the normal final iteration and an early exit.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_r      <= '0;
            b_r      <= '0;
            acc      <= '0;
            result_r <= '0;
        end else begin
            if (load) begin
                a_r <= bus.op_a;
                b_r <= bus.op_b;
                acc <= bus.op_c;
            end else if (step) begin
                acc <= next_acc;
                a_r <= a_r << 1;
                b_r <= b_r >> 1;
            end
            if (finish) begin
                result_r <= next_acc;
            end
        end
    end

    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.result = result_r;

endmodule
